writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Parametrised writeback arbiter that sits between the execution units' unit_writeback interfaces and the register-file write ports. Unit completions are grouped into independent writeback groups. Each group owns one register-file write port. Each group selects one done unit per cycle using a round-robin pointer, so a busy unit cannot starve the others in its group. The block also drives a registered snoop copy of one selectable group for load/store forwarding, and keeps per-group contention counters.

## Interface
Parameters:
- NUM_GROUPS, 2, number of writeback groups (and write ports); 1..4.
- NUM_UNITS, '{1,4,0,0}, units per group; entries at index NUM_GROUPS and above are ignored; each used entry is 1..8.
- NUM_WB_UNITS, 5, total units; equals the sum of the used NUM_UNITS entries.
- DATA_WIDTH, 32, writeback data width.
- SNOOP_GROUP, 1, group mirrored onto the snoop port; must be less than NUM_GROUPS.
- CNT_WIDTH, 16, width of each contention counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- unit_wb[NUM_WB_UNITS], unit_writeback_interface.wb, -, per-unit done/id/rd inputs and ack output. Units are packed group by group, in group order.
- wb_packet[NUM_GROUPS], out, wb_packet_t, per-port valid/id/data.
- wb_snoop, out, wb_packet_t, registered copy of wb_packet[SNOOP_GROUP].
- contention_count[NUM_GROUPS], out, CNT_WIDTH, cycles in which two or more units of the group were done at once.

## Operation
- Global index of unit j in group g is base(g) + j, where base(g) is the sum of NUM_UNITS for all groups below g.
- Per group g:
  - wb_packet[g].valid = OR of the group's done bits.
  - sel = first done unit found scanning upward from ptr[g], wrapping modulo NUM_UNITS[g].
  - wb_packet[g].id and .data are the selected unit's id and rd.
  - ack is asserted only to the selected unit, only when valid.
- Pointer update: on a clock edge with valid high, ptr[g] is set to (sel+1) mod NUM_UNITS[g]. With valid low, ptr[g] holds.
- A group with NUM_UNITS = 1 keeps ptr at 0 permanently. Its output is a pure pass-through.
- A unit holds done, id and rd until it is acked. A unit that is not acked stays pending, with no loss.
- Contention counter: contention_count[g] increments when the group's popcount(done) is 2 or more. It saturates at all-ones and does not wrap.
- Snoop: each cycle wb_snoop loads valid, id and data from wb_packet[SNOOP_GROUP].
- While rst is high:
  - every ack and every wb_packet.valid is forced to 0;
  - the pointers, snoop registers and counters are loaded with their reset values.
- Reset values: ptr = 0; wb_snoop.valid/id/data = 0; contention_count = 0.

## Timing
- wb_packet and ack are combinational from done, id, rd and ptr, giving 0-cycle latency. An ack in cycle N means the unit may drop done or present its next result in cycle N+1.
- ptr and the contention counters update at the end of cycle N.
- wb_snoop has 1-cycle latency: its value in cycle N+1 equals wb_packet[SNOOP_GROUP] in cycle N.
- If rst is deasserted in cycle N, the done bits in cycle N+1 are arbitrated from ptr = 0.
- If reset is asserted mid-burst, pending dones are not acked. They are re-arbitrated after reset if the units still hold them.
- Pointer wrap: with ptr = NUM_UNITS-1 and that unit granted, ptr becomes 0.

## Configuration
- WB_RR_ARB_EN defined: round-robin selection as described above.
- WB_RR_ARB_EN not defined: fixed priority, lowest index in the group wins.
  - The pointer registers are not built.
  - The contention counters and snoop behaviour are unchanged.

## Structure
- The shared package (cva5_types) holds:
  - wb_packet_t, which already exists;
  - the new wb_group_units_t array type for NUM_UNITS;
  - the constant MAX_WB_GROUPS_ARB = 4;
  - the function get_group_base(), which returns base(g).
- One sub-module, writeback_rr_arbiter, is instantiated once per group:
  - parameter WIDTH;
  - inputs: request vector, advance strobe, clk, rst;
  - outputs: one-hot grant and encoded select;
  - contains the pointer register and a masked, wrapped priority encoder;
  - falls back to a plain priority encoder when WB_RR_ARB_EN is undefined.

## Test plan
- Single unit in group 0 done with id 3, data 0xDEADBEEF -> wb_packet[0] is valid with id 3 and that data in the same cycle, and the unit is acked in the same cycle.
- Group 1 (4 units), all four done and held continuously -> grants are units 0,1,2,3,0 on consecutive cycles, and contention_count[1] increments every cycle. Without WB_RR_ARB_EN, unit 0 is granted every cycle.
- Group 1 with ptr = 3 and only unit 1 done -> unit 1 is granted (wrap scan), and ptr becomes 2.
- Group 1 unit 2 done with id 5, data 0x1234 in cycle N -> in cycle N+1, wb_snoop is valid with id 5 and data 0x1234. In the following idle cycle, wb_snoop.valid is 0.
- Hold two units of group 1 done for more than 2^CNT_WIDTH cycles -> contention_count[1] stops at 0xFFFF.
- Assert rst with all units done and ptr = 2 -> no acks, and every wb_packet.valid is 0. After release, the first grant is unit 0, and the counters and snoop read 0.

Source files
------------

// File: rtl/cva5_types.sv
// Shared types for the writeback path: packet format, per-group unit counts
// and the helper that locates a group's first unit in the flat unit list.
package cva5_types;

   localparam int XLEN = 32;
   localparam int ID_WIDTH = 4;
   localparam int MAX_WB_GROUPS_ARB = 4;

   typedef logic [ID_WIDTH-1:0] id_t;

   typedef struct packed {
      logic valid;
      id_t id;
      logic [XLEN-1:0] data;
   } wb_packet_t;

   typedef int wb_group_units_t [MAX_WB_GROUPS_ARB];

   // Units are packed group by group, so a group's base index is the
   // number of units in all groups below it.
   function automatic int get_group_base(input wb_group_units_t units, input int group);
      int base;
      base = 0;
      for (int i = 0; i < MAX_WB_GROUPS_ARB; i++) begin
         if (i < group) begin
            base += units[i];
         end
      end
      return base;
   endfunction

endpackage

// File: rtl/unit_writeback_interface.sv
// Completion handshake between one execution unit and the writeback arbiter.
// The unit holds done/id/rd until it sees ack.
interface unit_writeback_interface #(
   parameter int DATA_WIDTH = 32
);
   import cva5_types::*;

   logic ack;
   logic done;
   id_t id;
   logic [DATA_WIDTH-1:0] rd;

   modport unit (input ack, output done, id, rd);
   modport wb (output ack, input done, id, rd);

endinterface

// File: rtl/writeback_rr_arbiter.sv
// Per-group grant selection. With WB_RR_ARB_EN defined a rotating pointer
// gives round-robin fairness; otherwise the lowest requesting index wins and
// no pointer register exists.
module writeback_rr_arbiter
   import cva5_types::*;
#(
   parameter int WIDTH = 4,
   localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input logic clk,
   input logic rst,
   input logic [WIDTH-1:0] requests,
   input logic advance,
   output logic [WIDTH-1:0] grant,
   output logic [SEL_W-1:0] sel
);

   if (WIDTH == 1) begin : gen_single
      // A lone unit needs no arbitration at all
      assign grant = requests;
      assign sel = '0;
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, advance};
   end else begin : gen_multi
`ifdef WB_RR_ARB_EN
      logic [SEL_W-1:0] ptr;

      // Pointer moves just past the winner whenever the group grants
      always_ff @(posedge clk) begin
         if (rst) begin
            ptr <= '0;
         end else if (advance) begin
            ptr <= (sel == SEL_W'(WIDTH - 1)) ? '0 : sel + 1'b1;
         end
      end

      // Wrapped priority scan starting at the pointer position
      always_comb begin
         logic found;
         logic [SEL_W:0] sum;
         logic [SEL_W-1:0] idx;
         grant = '0;
         sel = '0;
         found = 1'b0;
         sum = '0;
         idx = '0;
         for (int i = 0; i < WIDTH; i++) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(i);
            if (sum >= (SEL_W + 1)'(WIDTH)) begin
               sum = sum - (SEL_W + 1)'(WIDTH);
            end
            idx = sum[SEL_W-1:0];
            if (!found && requests[idx]) begin
               found = 1'b1;
               grant[idx] = 1'b1;
               sel = idx;
            end
         end
      end
`else
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, advance};

      // Plain priority encoder: lowest requesting index wins
      always_comb begin
         logic found;
         logic [SEL_W-1:0] idx;
         grant = '0;
         sel = '0;
         found = 1'b0;
         idx = '0;
         for (int i = 0; i < WIDTH; i++) begin
            idx = SEL_W'(i);
            if (!found && requests[idx]) begin
               found = 1'b1;
               grant[idx] = 1'b1;
               sel = idx;
            end
         end
      end
`endif
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one register-file write port per group, one granted
// unit per group per cycle, a registered snoop copy of one group and
// saturating per-group contention counters.
// Build option: WB_RR_ARB_EN selects round-robin; default is fixed priority.
module writeback_arbiter
   import cva5_types::*;
#(
   parameter int NUM_GROUPS = 2,
   parameter wb_group_units_t NUM_UNITS = '{1, 4, 0, 0},
   parameter int NUM_WB_UNITS = 5,
   parameter int DATA_WIDTH = 32,
   parameter int SNOOP_GROUP = 1,
   parameter int CNT_WIDTH = 16
) (
   input logic clk,
   input logic rst,
   unit_writeback_interface.wb unit_wb [NUM_WB_UNITS],
   output wb_packet_t wb_packet [NUM_GROUPS],
   output wb_packet_t wb_snoop,
   output logic [CNT_WIDTH-1:0] contention_count [NUM_GROUPS]
);

   wb_packet_t packets [NUM_GROUPS];

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : gen_group
      localparam int N = NUM_UNITS[g];
      localparam int BASE = get_group_base(NUM_UNITS, g);
      localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

      logic [N-1:0] done;
      logic [N-1:0] grant;
      logic [SEL_W-1:0] sel;
      id_t ids [N];
      logic [DATA_WIDTH-1:0] rds [N];
      logic valid;
      logic multi;
      logic [CNT_WIDTH-1:0] count;
      wb_packet_t pkt;

      for (genvar j = 0; j < N; j++) begin : gen_unit
         assign done[j] = unit_wb[BASE + j].done;
         assign ids[j] = unit_wb[BASE + j].id;
         assign rds[j] = unit_wb[BASE + j].rd;
         assign unit_wb[BASE + j].ack = valid & grant[j];
      end

      // Reset masks the port so nothing is acked while rst is high
      assign valid = (|done) & ~rst;

      // Two or more done bits means clearing the lowest still leaves one
      assign multi = |(done & (done - 1'b1));

      writeback_rr_arbiter #(
         .WIDTH(N)
      ) arb (
         .clk(clk),
         .rst(rst),
         .requests(done),
         .advance(valid),
         .grant(grant),
         .sel(sel)
      );

      // Steer the selected unit's id and result onto the write port
      always_comb begin
         pkt = '0;
         pkt.valid = valid;
         for (int j = 0; j < N; j++) begin
            if (sel == SEL_W'(j)) begin
               pkt.id = ids[j];
               pkt.data[DATA_WIDTH-1:0] = rds[j];
            end
         end
      end

      // Count contended cycles, sticking at all-ones instead of wrapping
      always_ff @(posedge clk) begin
         if (rst) begin
            count <= '0;
         end else if (multi && (count != '1)) begin
            count <= count + 1'b1;
         end
      end

      assign packets[g] = pkt;
      assign contention_count[g] = count;
   end

   assign wb_packet = packets;

   // Snoop copy lags the chosen port by one cycle for forwarding
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_snoop <= '0;
      end else begin
         wb_snoop <= packets[SNOOP_GROUP];
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: group 0 has one unit, group 1 has
// four, snoop mirrors group 1, counters are 8 bits so saturation is quick.
module tb_writeback_arbiter;
   import cva5_types::*;

   logic clk;
   logic rst;
   logic [4:0] done_v;
   id_t id_v [5];
   logic [31:0] rd_v [5];
   logic [4:0] ack_v;
   wb_packet_t pkt [2];
   wb_packet_t wb_snoop;
   logic [7:0] cnt [2];

   int compared;
   int mismatched;

   unit_writeback_interface #(.DATA_WIDTH(32)) wb_if [5] ();

   for (genvar i = 0; i < 5; i++) begin : gen_if
      assign wb_if[i].done = done_v[i];
      assign wb_if[i].id = id_v[i];
      assign wb_if[i].rd = rd_v[i];
      assign ack_v[i] = wb_if[i].ack;
   end

   writeback_arbiter #(
      .NUM_GROUPS(2),
      .NUM_UNITS('{1, 4, 0, 0}),
      .NUM_WB_UNITS(5),
      .DATA_WIDTH(32),
      .SNOOP_GROUP(1),
      .CNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .unit_wb(wb_if),
      .wb_packet(pkt),
      .wb_snoop(wb_snoop),
      .contention_count(cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef WB_RR_ARB_EN
   localparam logic [4:0] BURST_ACK [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00010};
   localparam logic [3:0] BURST_ID [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd4};
   localparam logic [4:0] AFTER_WRAP_ACK = 5'b01000;
   localparam logic [4:0] POST_RESET_ACK2 = 5'b00101;
`else
   localparam logic [4:0] BURST_ACK [5] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010};
   localparam logic [3:0] BURST_ID [5] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd4};
   localparam logic [4:0] AFTER_WRAP_ACK = 5'b00010;
   localparam logic [4:0] POST_RESET_ACK2 = 5'b00011;
`endif

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] done, input logic r);
      done_v = done;
      rst = r;
      #2;
   endtask

   task automatic setUnit(input int i, input logic [3:0] id, input logic [31:0] data);
      id_v[i] = id;
      rd_v[i] = data;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      rst = 1'b1;
      done_v = '0;
      for (int i = 0; i < 5; i++) begin
         setUnit(i, 4'd0, 32'd0);
      end
      repeat (2) nextCycle();

      // Reset state
      applyStimulus(5'b00000, 1'b1);
      checkOutput("rst_snoop", 64'(wb_snoop), 64'd0);
      checkOutput("rst_cnt0", 64'(cnt[0]), 64'd0);
      checkOutput("rst_cnt1", 64'(cnt[1]), 64'd0);
      applyStimulus(5'b11111, 1'b1);
      checkOutput("rst_ack", 64'(ack_v), 64'd0);
      checkOutput("rst_valid0", 64'(pkt[0].valid), 64'd0);
      checkOutput("rst_valid1", 64'(pkt[1].valid), 64'd0);
      nextCycle();
      applyStimulus(5'b00000, 1'b0);
      checkOutput("idle_valid1", 64'(pkt[1].valid), 64'd0);
      checkOutput("idle_ack", 64'(ack_v), 64'd0);

      // Single-unit group passes through in the same cycle
      nextCycle();
      setUnit(0, 4'd3, 32'hDEADBEEF);
      applyStimulus(5'b00001, 1'b0);
      checkOutput("g0_valid", 64'(pkt[0].valid), 64'd1);
      checkOutput("g0_id", 64'(pkt[0].id), 64'd3);
      checkOutput("g0_data", 64'(pkt[0].data), 64'hDEADBEEF);
      checkOutput("g0_ack", 64'(ack_v), 64'b00001);
      checkOutput("g0_valid1", 64'(pkt[1].valid), 64'd0);

      // All four group-1 units held done
      nextCycle();
      for (int j = 0; j < 4; j++) begin
         setUnit(j + 1, 4'(j + 4), 32'h100 + 32'(j));
      end
      for (int k = 0; k < 5; k++) begin
         applyStimulus(5'b11110, 1'b0);
         checkOutput($sformatf("burst_ack%0d", k), 64'(ack_v), 64'(BURST_ACK[k]));
         checkOutput($sformatf("burst_id%0d", k), 64'(pkt[1].id), 64'(BURST_ID[k]));
         checkOutput($sformatf("burst_cnt%0d", k), 64'(cnt[1]), 64'(k));
         checkOutput($sformatf("burst_snoopv%0d", k), 64'(wb_snoop.valid), 64'(k > 0));
         if (k > 0) begin
            checkOutput($sformatf("burst_snoopid%0d", k), 64'(wb_snoop.id), 64'(BURST_ID[k-1]));
         end
         nextCycle();
      end

      // Single requests, including one behind the pointer
      applyStimulus(5'b01000, 1'b0);
      checkOutput("single_u2_ack", 64'(ack_v), 64'b01000);
      nextCycle();
      applyStimulus(5'b00100, 1'b0);
      checkOutput("wrap_u1_ack", 64'(ack_v), 64'b00100);
      checkOutput("wrap_cnt", 64'(cnt[1]), 64'd5);
      nextCycle();
      applyStimulus(5'b11110, 1'b0);
      checkOutput("after_wrap_ack", 64'(ack_v), 64'(AFTER_WRAP_ACK));
      nextCycle();

      // Snoop follows group 1 by one cycle
      setUnit(3, 4'd5, 32'h1234);
      applyStimulus(5'b01000, 1'b0);
      checkOutput("snoop_src_id", 64'(pkt[1].id), 64'd5);
      checkOutput("snoop_src_data", 64'(pkt[1].data), 64'h1234);
      nextCycle();
      applyStimulus(5'b00000, 1'b0);
      checkOutput("snoop_valid", 64'(wb_snoop.valid), 64'd1);
      checkOutput("snoop_id", 64'(wb_snoop.id), 64'd5);
      checkOutput("snoop_data", 64'(wb_snoop.data), 64'h1234);
      checkOutput("snoop_cnt", 64'(cnt[1]), 64'd6);
      nextCycle();
      applyStimulus(5'b00000, 1'b0);
      checkOutput("snoop_idle", 64'(wb_snoop.valid), 64'd0);

      // Counter saturation with two units held
      applyStimulus(5'b00110, 1'b0);
      repeat (248) nextCycle();
      #2;
      checkOutput("sat_pre", 64'(cnt[1]), 64'd254);
      repeat (10) nextCycle();
      #2;
      checkOutput("sat_hold", 64'(cnt[1]), 64'hFF);
      checkOutput("sat_cnt0", 64'(cnt[0]), 64'd0);

      // Reset in the middle of activity
      applyStimulus(5'b00100, 1'b0);
      checkOutput("pre_rst_ack", 64'(ack_v), 64'b00100);
      nextCycle();
      applyStimulus(5'b11111, 1'b1);
      checkOutput("mid_rst_ack", 64'(ack_v), 64'd0);
      checkOutput("mid_rst_valid0", 64'(pkt[0].valid), 64'd0);
      checkOutput("mid_rst_valid1", 64'(pkt[1].valid), 64'd0);
      nextCycle();
      applyStimulus(5'b11111, 1'b1);
      checkOutput("mid_rst_cnt1", 64'(cnt[1]), 64'd0);
      checkOutput("mid_rst_snoop", 64'(wb_snoop), 64'd0);
      nextCycle();
      applyStimulus(5'b11111, 1'b0);
      checkOutput("post_rst_ack", 64'(ack_v), 64'b00011);
      checkOutput("post_rst_cnt0", 64'(cnt[0]), 64'd0);
      checkOutput("post_rst_cnt1", 64'(cnt[1]), 64'd0);
      checkOutput("post_rst_snoopv", 64'(wb_snoop.valid), 64'd0);
      nextCycle();
      applyStimulus(5'b11111, 1'b0);
      checkOutput("post_rst_ack2", 64'(ack_v), 64'(POST_RESET_ACK2));
      checkOutput("post_rst_cnt1b", 64'(cnt[1]), 64'd1);
      checkOutput("post_rst_snoopid", 64'(wb_snoop.id), 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
